// File: rtl/sb_rx_msg_decoder_pkg.sv
// Shared definitions for the sideband RX message decoder: opcodes, header field
// positions, FSM state encoding and the decoded-field bundle.
package sb_rx_msg_decoder_pkg;

    localparam int unsigned SB_WORD_W = 64;

    // Supported sideband opcodes
    localparam logic [4:0] OPC_MSG_NODATA = 5'b10010;
    localparam logic [4:0] OPC_MSG_DATA   = 5'b11011;

    // Header field positions
    localparam int unsigned OPCODE_LSB     = 0;
    localparam int unsigned OPCODE_MSB     = 4;
    localparam int unsigned MSGCODE_LSB    = 14;
    localparam int unsigned MSGCODE_MSB    = 21;
    localparam int unsigned SRCID_LSB      = 29;
    localparam int unsigned SRCID_MSB      = 31;
    localparam int unsigned MSGSUBCODE_LSB = 32;
    localparam int unsigned MSGSUBCODE_MSB = 39;
    localparam int unsigned MSGINFO_LSB    = 40;
    localparam int unsigned MSGINFO_MSB    = 55;
    localparam int unsigned DSTID_LSB      = 56;
    localparam int unsigned DSTID_MSB      = 58;
    localparam int unsigned CP_BIT         = 62;
    localparam int unsigned DP_BIT         = 63;

    typedef enum logic [2:0] {
        StIdle,
        StHdrWait,
        StDataReq,
        StDataWait,
        StOut
    } dec_state_e;

    // Header fields presented to the consumer
    typedef struct packed {
        logic [4:0]  opcode;
        logic [7:0]  msgcode;
        logic [7:0]  msgsubcode;
        logic [15:0] msginfo;
        logic [2:0]  srcid;
        logic [2:0]  dstid;
    } sb_msg_fields_t;

    function automatic logic opcode_has_data(input logic [4:0] opcode);
        return opcode == OPC_MSG_DATA;
    endfunction

    function automatic logic opcode_supported(input logic [4:0] opcode);
        return (opcode == OPC_MSG_NODATA) || (opcode == OPC_MSG_DATA);
    endfunction

endpackage

// File: rtl/sb_rx_parity.sv
// Combinational even-parity checks for a sideband header (CP) and data word (DP).
module sb_rx_parity
    import sb_rx_msg_decoder_pkg::*;
(
    input  logic [CP_BIT:0]      hdr,
    input  logic [SB_WORD_W-1:0] data,
    input  logic                 dp,
    output logic                 cp_ok,
    output logic                 dp_ok
);

    // CP covers header bits below it; DP covers the full payload word
    always_comb begin
        cp_ok = ((^hdr[CP_BIT-1:0]) == hdr[CP_BIT]);
        dp_ok = ((^data) == dp);
    end

endmodule

// File: rtl/sb_rx_msg_decoder.sv
// Sideband RX message decoder. Drains header (and optional data) words from the
// SB RX FIFO, checks CP/DP parity and opcode, and presents one message per
// valid/ready handshake. Malformed messages are dropped with an error pulse.
module sb_rx_msg_decoder
    import sb_rx_msg_decoder_pkg::*;
#(
    parameter int unsigned DATA_TIMEOUT = 64,
    parameter int unsigned DROP_CNT_W   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fifo_empty,
    input  logic [SB_WORD_W-1:0]  i_fifo_data,
    output logic                  o_fifo_read_en,
    output logic                  o_msg_valid,
    input  logic                  i_msg_ready,
    output logic [4:0]            o_opcode,
    output logic [7:0]            o_msgcode,
    output logic [7:0]            o_msgsubcode,
    output logic [15:0]           o_msginfo,
    output logic [2:0]            o_srcid,
    output logic [2:0]            o_dstid,
    output logic                  o_has_data,
    output logic [SB_WORD_W-1:0]  o_data,
    output logic                  o_parity_err,
    output logic                  o_opcode_err,
    output logic                  o_timeout_err,
    output logic [DROP_CNT_W-1:0] o_drop_count
);

    localparam int unsigned         TO_CNT_W = $clog2(DATA_TIMEOUT + 1);
    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(DATA_TIMEOUT);

    dec_state_e            state_q, state_d;
    logic                  run_q;
    sb_msg_fields_t        hdr_fields;
    sb_msg_fields_t        fields_q, fields_d;
    logic                  dp_q, dp_d;
    logic [SB_WORD_W-1:0]  data_q, data_d;
    logic [TO_CNT_W-1:0]   to_cnt_q, to_cnt_d, to_cnt_inc;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  parity_err_q, parity_err_d;
    logic                  opcode_err_q, opcode_err_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  read_en;
    logic                  drop;
    logic                  cp_ok, dp_ok;

    // Parity of the word currently on the FIFO read port; cp_ok is used while it
    // is a header, dp_ok (against the latched DP bit) while it is the payload.
    sb_rx_parity u_parity (
        .hdr   (i_fifo_data[CP_BIT:0]),
        .data  (i_fifo_data),
        .dp    (dp_q),
        .cp_ok (cp_ok),
        .dp_ok (dp_ok)
    );

    // Slice the header fields out of the FIFO read word
    always_comb begin
        hdr_fields            = '0;
        hdr_fields.opcode     = i_fifo_data[OPCODE_MSB:OPCODE_LSB];
        hdr_fields.msgcode    = i_fifo_data[MSGCODE_MSB:MSGCODE_LSB];
        hdr_fields.msgsubcode = i_fifo_data[MSGSUBCODE_MSB:MSGSUBCODE_LSB];
        hdr_fields.msginfo    = i_fifo_data[MSGINFO_MSB:MSGINFO_LSB];
        hdr_fields.srcid      = i_fifo_data[SRCID_MSB:SRCID_LSB];
        hdr_fields.dstid      = i_fifo_data[DSTID_MSB:DSTID_LSB];
    end

    // Read enable is held off until the first clock after reset release so the
    // combinational strobe is never seen while reset is asserted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Next-state, FIFO strobe, field latching and error classification
    always_comb begin
        state_d       = state_q;
        fields_d      = fields_q;
        dp_d          = dp_q;
        data_d        = data_q;
        to_cnt_d      = to_cnt_q;
        to_cnt_inc    = to_cnt_q + 1'b1;
        read_en       = 1'b0;
        drop          = 1'b0;
        parity_err_d  = 1'b0;
        opcode_err_d  = 1'b0;
        timeout_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run_q && !i_fifo_empty) begin
                    read_en = 1'b1;
                    state_d = StHdrWait;
                end
            end

            StHdrWait: begin
                // Fields are only latched for accepted headers, so the outputs
                // keep the last good message across drops.
                if (!cp_ok) begin
                    parity_err_d = 1'b1;
                    drop         = 1'b1;
                    state_d      = StIdle;
                end else if (!opcode_supported(hdr_fields.opcode)) begin
                    opcode_err_d = 1'b1;
                    drop         = 1'b1;
                    state_d      = StIdle;
                end else begin
                    fields_d = hdr_fields;
                    dp_d     = i_fifo_data[DP_BIT];
                    data_d   = '0;
                    if (opcode_has_data(hdr_fields.opcode)) begin
                        to_cnt_d = '0;
                        state_d  = StDataReq;
                    end else begin
                        state_d = StOut;
                    end
                end
            end

            StDataReq: begin
                if (!i_fifo_empty) begin
                    read_en = 1'b1;
                    state_d = StDataWait;
                end else begin
                    to_cnt_d = to_cnt_inc;
                    if (to_cnt_inc == TO_LIMIT) begin
                        timeout_err_d = 1'b1;
                        drop          = 1'b1;
                        state_d       = StIdle;
                    end
                end
            end

            StDataWait: begin
                if (!dp_ok) begin
                    parity_err_d = 1'b1;
                    drop         = 1'b1;
                    state_d      = StIdle;
                end else begin
                    data_d  = i_fifo_data;
                    state_d = StOut;
                end
            end

            StOut: begin
                if (i_msg_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Saturating count of dropped messages
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // State, message registers, counters and error pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            fields_q      <= '0;
            dp_q          <= 1'b0;
            data_q        <= '0;
            to_cnt_q      <= '0;
            drop_cnt_q    <= '0;
            parity_err_q  <= 1'b0;
            opcode_err_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fields_q      <= fields_d;
            dp_q          <= dp_d;
            data_q        <= data_d;
            to_cnt_q      <= to_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            parity_err_q  <= parity_err_d;
            opcode_err_q  <= opcode_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign o_fifo_read_en = read_en;
    assign o_msg_valid    = (state_q == StOut);
    assign o_opcode       = fields_q.opcode;
    assign o_msgcode      = fields_q.msgcode;
    assign o_msgsubcode   = fields_q.msgsubcode;
    assign o_msginfo      = fields_q.msginfo;
    assign o_srcid        = fields_q.srcid;
    assign o_dstid        = fields_q.dstid;
    assign o_has_data     = opcode_has_data(fields_q.opcode);
    assign o_data         = o_has_data ? data_q : '0;
    assign o_parity_err   = parity_err_q;
    assign o_opcode_err   = opcode_err_q;
    assign o_timeout_err  = timeout_err_q;
    assign o_drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_sb_rx_msg_decoder.sv
// Directed bench for sb_rx_msg_decoder with a behavioural SB RX FIFO whose
// empty flag lags reads by one cycle.
module tb_sb_rx_msg_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [63:0] fifo_rdata = '0;
    logic        read_en;
    logic        msg_valid;
    logic        msg_ready = 1'b0;
    logic [4:0]  opcode;
    logic [7:0]  msgcode;
    logic [7:0]  msgsubcode;
    logic [15:0] msginfo;
    logic [2:0]  srcid;
    logic [2:0]  dstid;
    logic        has_data;
    logic [63:0] data;
    logic        parity_err;
    logic        opcode_err;
    logic        timeout_err;
    logic [7:0]  drop_count;

    int          vectors = 0;
    int          errors = 0;
    int          strobe_cnt = 0;
    logic        prev_strobe = 1'b0;
    logic [63:0] fq[$];
    logic [7:0]  rx_q[$];

    always #5 clk = ~clk;

    sb_rx_msg_decoder dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_fifo_empty   (fifo_empty),
        .i_fifo_data    (fifo_rdata),
        .o_fifo_read_en (read_en),
        .o_msg_valid    (msg_valid),
        .i_msg_ready    (msg_ready),
        .o_opcode       (opcode),
        .o_msgcode      (msgcode),
        .o_msgsubcode   (msgsubcode),
        .o_msginfo      (msginfo),
        .o_srcid        (srcid),
        .o_dstid        (dstid),
        .o_has_data     (has_data),
        .o_data         (data),
        .o_parity_err   (parity_err),
        .o_opcode_err   (opcode_err),
        .o_timeout_err  (timeout_err),
        .o_drop_count   (drop_count)
    );

    // FIFO model: data valid the cycle after a read, empty flag registered from
    // the occupancy before the read (so it lags the read by one cycle).
    always @(posedge clk) begin
        int sz;
        sz = fq.size();
        if (read_en && sz > 0) fifo_rdata <= fq.pop_front();
        fifo_empty <= (sz == 0);
    end

    // Continuous protocol checks and delivery capture
    always @(negedge clk) begin
        if (read_en) begin
            strobe_cnt++;
            vectors++;
            assert (!fifo_empty && fq.size() > 0) else begin
                errors++;
                $error("FAIL strobe_on_empty: empty=%0b depth=%0d required empty=0 depth>0",
                       fifo_empty, fq.size());
            end
            vectors++;
            assert (!prev_strobe) else begin
                errors++;
                $error("FAIL strobe_gap: observed back-to-back strobes required a gap cycle");
            end
        end
        prev_strobe = read_en;
        if (parity_err || opcode_err || timeout_err) begin
            vectors++;
            assert ($countones({parity_err, opcode_err, timeout_err}) == 1) else begin
                errors++;
                $error("FAIL err_exclusive: observed %b required one-hot",
                       {parity_err, opcode_err, timeout_err});
            end
        end
        if (msg_valid && msg_ready) rx_q.push_back(msgcode);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!read_en && n < 20);
        check(tag, {63'd0, read_en}, 64'd1);
    endtask

    initial begin
        // ---- reset state, and no read while reset is held
        repeat (3) tick();
        check("rst_read_en", {63'd0, read_en}, 64'd0);
        check("rst_valid", {63'd0, msg_valid}, 64'd0);
        check("rst_drop", {56'd0, drop_count}, 64'd0);
        check("rst_errs", {61'd0, parity_err, opcode_err, timeout_err}, 64'd0);
        check("rst_fields", {opcode, has_data, data[57:0]}, 64'd0);
        fq.push_back(64'h4000_0000_0000_0032);
        tick();
        tick();
        check("rst_no_strobe", {63'd0, read_en}, 64'd0);

        // ---- no-data message, ready high: valid 2 cycles after the strobe
        rst_n = 1'b1;
        msg_ready = 1'b1;
        wait_strobe("t1_strobe");
        tick();
        check("t1_valid_early", {63'd0, msg_valid}, 64'd0);
        tick();
        check("t1_valid", {63'd0, msg_valid}, 64'd1);
        check("t1_opcode", {59'd0, opcode}, 64'h12);
        check("t1_has_data", {63'd0, has_data}, 64'd0);
        check("t1_data", data, 64'd0);
        tick();
        check("t1_valid_fall", {63'd0, msg_valid}, 64'd0);

        // ---- field extraction
        fq.push_back(64'h05AB_CD3C_6016_8012);
        wait_strobe("t1b_strobe");
        tick();
        tick();
        check("t1b_valid", {63'd0, msg_valid}, 64'd1);
        check("t1b_msgcode", {56'd0, msgcode}, 64'h5A);
        check("t1b_subcode", {56'd0, msgsubcode}, 64'h3C);
        check("t1b_msginfo", {48'd0, msginfo}, 64'hABCD);
        check("t1b_srcid", {61'd0, srcid}, 64'd3);
        check("t1b_dstid", {61'd0, dstid}, 64'd5);
        tick();

        // ---- with-data message: data strobe, latency 4, exactly 2 strobes
        strobe_cnt = 0;
        fq.push_back(64'h0000_0000_0000_001B);
        fq.push_back(64'hDEAD_BEEF_0123_4567);
        wait_strobe("t2_hdr_strobe");
        tick();
        tick();
        check("t2_data_strobe", {63'd0, read_en}, 64'd1);
        tick();
        check("t2_valid_early", {63'd0, msg_valid}, 64'd0);
        tick();
        check("t2_valid", {63'd0, msg_valid}, 64'd1);
        check("t2_opcode", {59'd0, opcode}, 64'h1B);
        check("t2_has_data", {63'd0, has_data}, 64'd1);
        check("t2_data", data, 64'hDEAD_BEEF_0123_4567);
        repeat (3) tick();
        check("t2_strobes", strobe_cnt, 64'd2);

        // ---- CP error, following word parsed as a header
        fq.push_back(64'h4000_0000_0000_0012);
        fq.push_back(64'h0000_0000_001D_C012);
        wait_strobe("t3_strobe");
        tick();
        tick();
        check("t3_parity_err", {63'd0, parity_err}, 64'd1);
        check("t3_opcode_err", {63'd0, opcode_err}, 64'd0);
        check("t3_no_valid", {63'd0, msg_valid}, 64'd0);
        check("t3_drop", {56'd0, drop_count}, 64'd1);
        check("t3_next_strobe", {63'd0, read_en}, 64'd1);
        tick();
        check("t3_pulse_end", {63'd0, parity_err}, 64'd0);
        tick();
        check("t3_next_valid", {63'd0, msg_valid}, 64'd1);
        check("t3_next_msgcode", {56'd0, msgcode}, 64'h77);
        tick();

        // ---- data word never arrives: timeout after DATA_TIMEOUT empty cycles
        fq.push_back(64'h0000_0000_0000_001B);
        wait_strobe("t4_strobe");
        begin
            int n = 0;
            do begin
                tick();
                n++;
            end while (!timeout_err && n < 200);
            check("t4_timeout_cycles", n, 64'd66);
        end
        check("t4_drop", {56'd0, drop_count}, 64'd2);
        check("t4_no_valid", {63'd0, msg_valid}, 64'd0);
        tick();
        check("t4_pulse_end", {63'd0, timeout_err}, 64'd0);
        fq.push_back(64'h4000_0000_0000_0032);
        wait_strobe("t4_recover_strobe");
        tick();
        tick();
        check("t4_recover_valid", {63'd0, msg_valid}, 64'd1);
        check("t4_recover_opcode", {59'd0, opcode}, 64'h12);
        tick();

        // ---- unsupported opcode
        fq.push_back(64'h0000_0000_0000_0005);
        wait_strobe("t5_strobe");
        tick();
        tick();
        check("t5_opcode_err", {63'd0, opcode_err}, 64'd1);
        check("t5_parity_err", {63'd0, parity_err}, 64'd0);
        check("t5_drop", {56'd0, drop_count}, 64'd3);
        check("t5_no_valid", {63'd0, msg_valid}, 64'd0);
        tick();
        check("t5_pulse_end", {63'd0, opcode_err}, 64'd0);

        // ---- DP error on the payload word
        fq.push_back(64'h0000_0000_0000_001B);
        fq.push_back(64'h0000_0000_0000_0001);
        wait_strobe("t6_strobe");
        repeat (4) tick();
        check("t6_parity_err", {63'd0, parity_err}, 64'd1);
        check("t6_drop", {56'd0, drop_count}, 64'd4);
        check("t6_no_valid", {63'd0, msg_valid}, 64'd0);

        // ---- backpressure with four queued messages
        msg_ready = 1'b0;
        rx_q.delete();
        fq.push_back(64'h4000_0000_0000_4012);
        fq.push_back(64'h4000_0000_0000_8012);
        fq.push_back(64'h0000_0000_0000_C012);
        fq.push_back(64'h4000_0000_0001_0012);
        wait_strobe("t7_strobe");
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t7_hold_valid", {63'd0, msg_valid}, 64'd1);
            check("t7_hold_msgcode", {56'd0, msgcode}, 64'd1);
            check("t7_no_strobe", {63'd0, read_en}, 64'd0);
            tick();
        end
        msg_ready = 1'b1;
        begin
            int n = 0;
            while (rx_q.size() < 4 && n < 100) begin
                tick();
                n++;
            end
        end
        check("t7_count", rx_q.size(), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t7_order%0d", i), {56'd0, rx_q[i]}, 64'(i + 1));
        end

        // ---- reset asserted in DATA_WAIT, then clean restart
        msg_ready = 1'b0;
        fq.push_back(64'h0000_0000_0000_001B);
        fq.push_back(64'hDEAD_BEEF_0123_4567);
        wait_strobe("t8_strobe");
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t8_rst_read_en", {63'd0, read_en}, 64'd0);
        check("t8_rst_valid", {63'd0, msg_valid}, 64'd0);
        check("t8_rst_drop", {56'd0, drop_count}, 64'd0);
        check("t8_rst_opcode", {59'd0, opcode}, 64'd0);
        check("t8_rst_data", data, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        msg_ready = 1'b1;
        fq.push_back(64'h4000_0000_0000_0032);
        wait_strobe("t8_restart_strobe");
        tick();
        tick();
        check("t8_restart_valid", {63'd0, msg_valid}, 64'd1);
        check("t8_restart_opcode", {59'd0, opcode}, 64'h12);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
